// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: opcodes, writeback-source codes and the ID/EX control bundle
package pipelined_control_unit_pkg;
    localparam logic [6:0] INST_TYPE_R = 7'b0110011;
    localparam logic [6:0] INST_TYPE_I = 7'b0010011;
    localparam logic [6:0] INST_TYPE_L = 7'b0000011;
    localparam logic [6:0] INST_TYPE_S = 7'b0100011;
    localparam logic [6:0] INST_TYPE_B = 7'b1100011;
    localparam logic [6:0] INST_LUI    = 7'b0110111;
    localparam logic [6:0] INST_AUIPC  = 7'b0010111;
    localparam logic [6:0] INST_JAL    = 7'b1101111;
    localparam logic [6:0] INST_JALR   = 7'b1100111;
    localparam logic [1:0] FROM_ALU    = 2'd0;
    localparam logic [1:0] FROM_MEM    = 2'd1;
    localparam logic [1:0] FROM_PC     = 2'd2;
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] reg_src;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;
    localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/pipelined_control_unit_decode.sv
// control_decode: combinational RV32I opcode decode into the control bundle and operand-use flags
module control_decode
    import pipelined_control_unit_pkg::*;
#(
    parameter int HAS_ILLEGAL_TRAP = 1
) (
    input  logic [14:0] instr,
    output ctrl_t       ctrl,
    output logic        use1,
    output logic        use2
);
    logic legal;
    always_comb begin
        ctrl  = BUBBLE;
        use1  = 1'b0;
        use2  = 1'b0;
        legal = 1'b1;
        case (instr[6:0])
            INST_TYPE_R: begin ctrl.reg_write = 1'b1; use1 = 1'b1; use2 = 1'b1; end
            INST_TYPE_I: begin ctrl.reg_write = 1'b1; use1 = 1'b1; end
            INST_TYPE_L: begin ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1; ctrl.reg_src = FROM_MEM; use1 = 1'b1; end
            INST_TYPE_S: begin ctrl.mem_write = 1'b1; use1 = 1'b1; use2 = 1'b1; end
            INST_TYPE_B: begin ctrl.branch = 1'b1; use1 = 1'b1; use2 = 1'b1; end
            INST_LUI, INST_AUIPC: ctrl.reg_write = 1'b1;
            INST_JAL:    begin ctrl.reg_write = 1'b1; ctrl.jal = 1'b1; ctrl.reg_src = FROM_PC; end
            INST_JALR:   begin ctrl.reg_write = 1'b1; ctrl.jalr = 1'b1; ctrl.reg_src = FROM_PC; use1 = 1'b1; end
            default:     begin legal = 1'b0; ctrl.illegal = HAS_ILLEGAL_TRAP != 0; end
        endcase
        ctrl.rd     = ctrl.reg_write ? instr[11:7] : 5'd0;
        ctrl.funct3 = legal ? instr[14:12] : 3'd0;
    end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID decode, load-use stall counter, redirect squash and ID/EX control registers
module pipelined_control_unit
    import pipelined_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_USE_STALL   = 1,
    parameter int HAS_ILLEGAL_TRAP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           id_instr,
    input  logic                  id_valid,
    input  logic                  ex_redirect,
    input  logic                  ext_stall,
    output logic [REG_ADDR_W-1:0] id_rs1,
    output logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [2:0]            ex_funct3,
    output logic [1:0]            ex_reg_src,
    output logic                  ex_branch,
    output logic                  ex_jal,
    output logic                  ex_jalr,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_reg_write,
    output logic                  ex_illegal
);
    ctrl_t      dec, ctrl_d, ctrl_q;
    logic       use1, use2, hz, unused_hi;
    logic [2:0] cnt_d, cnt_q;
    control_decode #(.HAS_ILLEGAL_TRAP(HAS_ILLEGAL_TRAP)) u_decode (
        .instr (id_instr[14:0]),
        .ctrl  (dec),
        .use1  (use1),
        .use2  (use2)
    );
    assign unused_hi = ^id_instr[31:25];
    assign id_rs1    = REG_ADDR_W'(id_instr[19:15]);
    assign id_rs2    = REG_ADDR_W'(id_instr[24:20]);
    assign hz = id_valid & ctrl_q.mem_read & (ex_rd != '0) &
                ((use1 & (id_rs1 == ex_rd)) | (use2 & (id_rs2 == ex_rd)));
    // ext_stall outranks ex_redirect: EX is frozen and will present the redirect again
    always_comb begin
        ctrl_d      = ctrl_q;
        cnt_d       = cnt_q;
        pc_stall    = 1'b0;
        if_id_flush = 1'b0;
        if (ext_stall) begin
            pc_stall = 1'b1;
        end else if (ex_redirect) begin
            ctrl_d      = BUBBLE;
            cnt_d       = 3'd0;
            if_id_flush = 1'b1;
        end else if (cnt_q != 3'd0) begin
            ctrl_d   = BUBBLE;
            cnt_d    = cnt_q - 3'd1;
            pc_stall = 1'b1;
        end else if (hz) begin
            ctrl_d   = BUBBLE;
            cnt_d    = 3'(LOAD_USE_STALL - 1);
            pc_stall = 1'b1;
        end else begin
            ctrl_d = id_valid ? dec : BUBBLE;
        end
    end
    assign if_id_stall = pc_stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= BUBBLE;
            cnt_q  <= 3'd0;
        end else begin
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
        end
    end
    assign ex_rd        = REG_ADDR_W'(ctrl_q.rd);
    assign ex_funct3    = ctrl_q.funct3;
    assign ex_reg_src   = ctrl_q.reg_src;
    assign ex_branch    = ctrl_q.branch;
    assign ex_jal       = ctrl_q.jal;
    assign ex_jalr      = ctrl_q.jalr;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_illegal   = ctrl_q.illegal;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed scoreboard bench over two instances (LOAD_USE_STALL 1 and 3)
module tb_pipelined_control_unit;
    localparam logic [31:0] ADD_1_2_3 = 32'h003100B3;
    localparam logic [31:0] ADD_5_6_7 = 32'h007302B3;
    localparam logic [31:0] SW_5_6    = {7'd0, 5'd5, 5'd6, 3'd2, 5'd0, 7'b0100011};
    localparam logic [31:0] LW_5_1    = {12'd0, 5'd1, 3'd2, 5'd5, 7'b0000011};
    localparam logic [31:0] LW_0_1    = {12'd0, 5'd1, 3'd2, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_6_5_2 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_1_0_0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd1, 7'b0110011};
    localparam logic [31:0] LUI_7     = {7'd0, 5'd5, 5'd5, 3'd0, 5'd7, 7'b0110111};
    localparam logic [31:0] JAL_1     = {7'd0, 5'd5, 5'd5, 3'd0, 5'd1, 7'b1101111};
    localparam logic [31:0] ILL_7F    = 32'h0000007F;
    // expected ex vector: {rd, funct3, reg_src, branch, jal, jalr, mem_read, mem_write, reg_write, illegal}
    localparam logic [16:0] X_BUB  = 17'd0;
    localparam logic [16:0] X_ADD5 = {5'd5, 3'd0, 2'd0, 7'b0000010};
    localparam logic [16:0] X_SW   = {5'd0, 3'd2, 2'd0, 7'b0000100};
    localparam logic [16:0] X_LW5  = {5'd5, 3'd2, 2'd1, 7'b0001010};
    localparam logic [16:0] X_LW0  = {5'd0, 3'd2, 2'd1, 7'b0001010};
    localparam logic [16:0] X_ADD6 = {5'd6, 3'd0, 2'd0, 7'b0000010};
    localparam logic [16:0] X_ADD1 = {5'd1, 3'd0, 2'd0, 7'b0000010};
    localparam logic [16:0] X_LUI7 = {5'd7, 3'd0, 2'd0, 7'b0000010};
    localparam logic [16:0] X_JAL1 = {5'd1, 3'd0, 2'd2, 7'b0100010};
    localparam logic [16:0] X_ILL  = {5'd0, 3'd0, 2'd0, 7'b0000001};

    typedef struct {
        int          d;
        logic [16:0] v;
        string       tag;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr [2];
    logic        valid [2];
    logic        redir [2];
    logic        stall [2];
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];
    logic        pc_stall [2];
    logic        if_id_stall [2];
    logic        if_id_flush [2];
    logic [4:0]  ex_rd [2];
    logic [2:0]  ex_funct3 [2];
    logic [1:0]  ex_reg_src [2];
    logic        ex_branch [2];
    logic        ex_jal [2];
    logic        ex_jalr [2];
    logic        ex_mem_read [2];
    logic        ex_mem_write [2];
    logic        ex_reg_write [2];
    logic        ex_illegal [2];
    logic [16:0] exv [2];
    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipelined_control_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(g == 0 ? 1 : 3), .HAS_ILLEGAL_TRAP(1)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .id_instr     (instr[g]),
            .id_valid     (valid[g]),
            .ex_redirect  (redir[g]),
            .ext_stall    (stall[g]),
            .id_rs1       (rs1[g]),
            .id_rs2       (rs2[g]),
            .pc_stall     (pc_stall[g]),
            .if_id_stall  (if_id_stall[g]),
            .if_id_flush  (if_id_flush[g]),
            .ex_rd        (ex_rd[g]),
            .ex_funct3    (ex_funct3[g]),
            .ex_reg_src   (ex_reg_src[g]),
            .ex_branch    (ex_branch[g]),
            .ex_jal       (ex_jal[g]),
            .ex_jalr      (ex_jalr[g]),
            .ex_mem_read  (ex_mem_read[g]),
            .ex_mem_write (ex_mem_write[g]),
            .ex_reg_write (ex_reg_write[g]),
            .ex_illegal   (ex_illegal[g])
        );
        assign exv[g] = {ex_rd[g], ex_funct3[g], ex_reg_src[g], ex_branch[g], ex_jal[g], ex_jalr[g],
                         ex_mem_read[g], ex_mem_write[g], ex_reg_write[g], ex_illegal[g]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // drive one cycle, check comb stall/flush, queue the ID/EX result and compare it after the edge
    task automatic step(input int d, input logic [31:0] ins, input logic v, input logic r, input logic s,
                        input logic eps, input logic efl, input logic [16:0] eex, input string tag);
        sb_t e;
        instr[d] = ins;
        valid[d] = v;
        redir[d] = r;
        stall[d] = s;
        #1;
        chk({tag, ".pc_stall"}, 32'(pc_stall[d]), 32'(eps));
        chk({tag, ".if_id_stall"}, 32'(if_id_stall[d]), 32'(eps));
        chk({tag, ".if_id_flush"}, 32'(if_id_flush[d]), 32'(efl));
        sb.push_back('{d, eex, tag});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".ex"}, 32'(exv[e.d]), 32'(e.v));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            instr[i] = ADD_1_2_3;
            valid[i] = 1'b1;
            redir[i] = 1'b0;
            stall[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d.ex", i), 32'(exv[i]), 32'(X_BUB));
            chk($sformatf("reset%0d.pc_stall", i), 32'(pc_stall[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        // LOAD_USE_STALL = 1
        step(0, ADD_5_6_7, 1, 0, 0, 0, 0, X_ADD5, "add5");
        step(0, SW_5_6,    1, 0, 0, 0, 0, X_SW,   "sw");
        step(0, LW_5_1,    1, 0, 0, 0, 0, X_LW5,  "lw5_a");
        step(0, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "lu1_bubble");
        step(0, ADD_6_5_2, 1, 0, 0, 0, 0, X_ADD6, "lu1_add");
        step(0, LW_5_1,    1, 0, 0, 0, 0, X_LW5,  "lw5_b");
        step(0, LUI_7,     1, 0, 0, 0, 0, X_LUI7, "lui_nostall");
        step(0, LW_0_1,    1, 0, 0, 0, 0, X_LW0,  "lw0");
        step(0, ADD_1_0_0, 1, 0, 0, 0, 0, X_ADD1, "x0_nostall");
        step(0, LW_5_1,    1, 0, 0, 0, 0, X_LW5,  "lw5_c");
        step(0, JAL_1,     1, 0, 0, 0, 0, X_JAL1, "jal_nostall");
        step(0, ILL_7F,    1, 0, 0, 0, 0, X_ILL,  "illegal");
        step(0, ADD_1_2_3, 0, 0, 0, 0, 0, X_BUB,  "invalid");
        // LOAD_USE_STALL = 3
        step(1, LW_5_1,    1, 0, 0, 0, 0, X_LW5,  "s3_lw");
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "s3_b1");
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "s3_b2");
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "s3_b3");
        step(1, ADD_6_5_2, 1, 0, 0, 0, 0, X_ADD6, "s3_add");
        step(1, LW_5_1,    1, 0, 0, 0, 0, X_LW5,  "rd_lw");
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "rd_hz");
        step(1, ADD_6_5_2, 1, 1, 0, 0, 1, X_BUB,  "rd_redirect");
        step(1, ADD_6_5_2, 1, 0, 0, 0, 0, X_ADD6, "rd_after");
        step(1, LW_5_1,    1, 0, 0, 0, 0, X_LW5,  "fz_lw");
        for (int i = 0; i < 4; i++)
            step(1, ADD_6_5_2, 1, i == 2, 1, 1, 0, X_LW5, $sformatf("fz_hold%0d", i));
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "fz_b1");
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "fz_b2");
        for (int i = 0; i < 4; i++)
            step(1, ADD_6_5_2, 1, 0, 1, 1, 0, X_BUB, $sformatf("fz_mid%0d", i));
        step(1, ADD_6_5_2, 1, 0, 0, 1, 0, X_BUB,  "fz_b3");
        step(1, ADD_6_5_2, 1, 0, 0, 0, 0, X_ADD6, "fz_add");
        step(1, ILL_7F,    1, 0, 0, 0, 0, X_ILL,  "s3_illegal");
        instr[0] = ADD_6_5_2;
        #1;
        chk("id_rs1", 32'(rs1[0]), 32'd5);
        chk("id_rs2", 32'(rs2[0]), 32'd2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
